// File: rtl/exu_posu_sched_pkg.sv
// Shared types for the posit-unit scheduler: opcode, scheduler state and the NaR encoding.
package veer_types;
  typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11} posu_op_e;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DRAIN_WB, WB} posu_sched_state_e;
  localparam logic [31:0] POSIT_NAR = 32'h8000_0000;
endpackage

// File: rtl/exu_posu_sched_if.sv
// Issue, unit and writeback signals of the posit scheduler; slave is the scheduler's view.
interface exu_posu_sched_if #(parameter int TAG_W = 5);
  logic             req_valid;
  logic [1:0]       req_op;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready, posu_stall, flush;
  logic [31:0]      unit_in1, unit_in2;
  logic             add_start, mul_start, div_start;
  logic             add_done, mul_done, div_done;
  logic [31:0]      add_out, mul_out, div_out;
  logic             wb_valid, wb_err, wb_ready;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, flush,
           add_done, mul_done, div_done, add_out, mul_out, div_out, wb_ready,
    output req_ready, posu_stall, unit_in1, unit_in2, add_start, mul_start, div_start,
           wb_valid, wb_data, wb_tag, wb_err
  );
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, flush,
           add_done, mul_done, div_done, add_out, mul_out, div_out, wb_ready,
    input  req_ready, posu_stall, unit_in1, unit_in2, add_start, mul_start, div_start,
           wb_valid, wb_data, wb_tag, wb_err
  );
endinterface

// File: rtl/exu_posu_sched_wdog.sv
// Watchdog for the WAIT state: cleared on issue, counts while enabled, flags the last cycle.
module exu_posu_wdog #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/exu_posu_sched.sv
// Single-issue sequencer feeding the posit add/mul(/div) units with timeout and flush drain.
// Define POSU_DIV_EN to dispatch div ops to the divider; otherwise div returns NaR with error.
module exu_posu_sched
  import veer_types::*;
#(
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input logic              clk,
  input logic              rst_l,
  exu_posu_sched_if.slave  bus
);
  posu_sched_state_e state_q;
  posu_op_e          op_q, req_op;
  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       in1_q, in2_q, wb_data_q, sel_out;
  logic              add_start_q, mul_start_q, wb_valid_q, wb_err_q, late_q;
  logic              sel_done, wdog_exp, idle;

  assign req_op = posu_op_e'(bus.req_op);
  assign idle   = (state_q == IDLE);

  // Only the unit that owns the in-flight op may complete it.
  always_comb begin
    sel_done = 1'b0;
    sel_out  = bus.add_out;
    case (op_q)
      ADD, SUB: begin sel_done = bus.add_done; sel_out = bus.add_out; end
      MUL:      begin sel_done = bus.mul_done; sel_out = bus.mul_out; end
      default: begin
`ifdef POSU_DIV_EN
        sel_done = bus.div_done;
        sel_out  = bus.div_out;
`endif
      end
    endcase
  end

  exu_posu_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_wdog (
    .clk      (clk),
    .rst_l    (rst_l),
    .clr_i    (state_q == ISSUE),
    .en_i     (state_q == WAIT),
    .expire_o (wdog_exp)
  );

`ifdef POSU_DIV_EN
  logic div_start_q;
  assign bus.div_start = div_start_q;
`else
  logic unused_div;
  assign unused_div    = ^{bus.div_done, bus.div_out};
  assign bus.div_start = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      op_q        <= ADD;
      tag_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      add_start_q <= 1'b0;
      mul_start_q <= 1'b0;
`ifdef POSU_DIV_EN
      div_start_q <= 1'b0;
`endif
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      add_start_q <= 1'b0;
      mul_start_q <= 1'b0;
`ifdef POSU_DIV_EN
      div_start_q <= 1'b0;
`endif
      case (state_q)
        IDLE: if (bus.req_valid && !bus.flush) begin
          op_q  <= req_op;
          tag_q <= bus.req_tag;
          in1_q <= bus.req_a;
          in2_q <= (req_op == SUB) ? (32'd0 - bus.req_b) : bus.req_b;
`ifndef POSU_DIV_EN
          if (req_op == DIV) begin
            state_q    <= WB;
            wb_valid_q <= 1'b1;
            wb_data_q  <= POSIT_NAR;
            wb_err_q   <= 1'b1;
          end else
`endif
          begin
            state_q     <= ISSUE;
            add_start_q <= (req_op == ADD) || (req_op == SUB);
            mul_start_q <= (req_op == MUL);
`ifdef POSU_DIV_EN
            div_start_q <= (req_op == DIV);
`endif
          end
        end
        ISSUE: state_q <= bus.flush ? DRAIN : WAIT;
        WAIT: begin
          if (bus.flush) begin
            state_q <= DRAIN;
          end else if (sel_done) begin
            state_q    <= WB;
            wb_valid_q <= 1'b1;
            wb_data_q  <= sel_out;
            wb_err_q   <= 1'b0;
          end else if (wdog_exp) begin
            state_q    <= DRAIN_WB;
            wb_valid_q <= 1'b1;
            wb_data_q  <= POSIT_NAR;
            wb_err_q   <= 1'b1;
            late_q     <= 1'b0;
          end
        end
        DRAIN: if (sel_done) state_q <= IDLE;
        // The timed-out unit is still busy: leave only once both the result and its done are gone.
        DRAIN_WB: begin
          if (bus.flush || bus.wb_ready) wb_valid_q <= 1'b0;
          if (sel_done) late_q <= 1'b1;
          if ((!wb_valid_q || bus.flush || bus.wb_ready) && (late_q || sel_done))
            state_q <= IDLE;
        end
        WB: if (bus.flush || bus.wb_ready) begin
          wb_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = idle;
  assign bus.posu_stall = bus.req_valid & ~idle;
  assign bus.unit_in1   = in1_q;
  assign bus.unit_in2   = in2_q;
  assign bus.add_start  = add_start_q;
  assign bus.mul_start  = mul_start_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_tag     = tag_q;
  assign bus.wb_err     = wb_err_q;
endmodule
